// File: rtl/riscv_hazard_ctrl.sv
// Purpose: in-order issue hazard control: load-use interlock, operand forwarding selects, EX/MEM slot tracking.
// Latency: id_ready and fwd_a/fwd_b are combinational from ID inputs and slot state; slots update one edge later.
// Backpressure: a load-use hazard, flush or mem_stall holds id_ready low; mem_stall freezes both slots.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_is_load
//                                decoded instruction offered for issue
//   flush                        branch redirect: squashes EX and blocks issue
//   mem_stall                    memory busy: freezes EX and MEM, blocks issue
//   id_ready                     offered instruction issues this cycle
//   ex_valid, ex_rd, mem_rd      registered slot state
//   fwd_a, fwd_b                 operand select: 0 regfile, 1 EX result, 2 MEM result
//   stall_cnt                    saturating count of load-use stall cycles
module riscv_hazard_ctrl #(
    parameter int REGN = 32,
    parameter int REGA = $clog2(REGN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGA-1:0] id_rs1,
    input  logic [REGA-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGA-1:0] id_rd,
    input  logic            id_is_load,
    input  logic            flush,
    input  logic            mem_stall,
    output logic            id_ready,
    output logic            ex_valid,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [REGA-1:0] ex_rd,
    output logic [REGA-1:0] mem_rd,
    output logic [15:0]     stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    logic ex_v, ex_ld;
    logic mem_v, mem_ld;

    logic ex_wr, mem_wr;
    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic load_use;
    logic count_stall;

    // x0 is hardwired zero: a slot targeting it never produces a result worth forwarding.
    assign ex_wr  = ex_v  && (ex_rd  != '0);
    assign mem_wr = mem_v && (mem_rd != '0);

    assign rs1_ex  = id_use_rs1 && (id_rs1 != '0) && ex_wr  && (id_rs1 == ex_rd);
    assign rs2_ex  = id_use_rs2 && (id_rs2 != '0) && ex_wr  && (id_rs2 == ex_rd);
    assign rs1_mem = id_use_rs1 && (id_rs1 != '0) && mem_wr && (id_rs1 == mem_rd);
    assign rs2_mem = id_use_rs2 && (id_rs2 != '0) && mem_wr && (id_rs2 == mem_rd);

    // A load in EX has no data yet; the consumer must wait one cycle and take it from MEM.
    assign load_use = (rs1_ex || rs2_ex) && ex_ld;

    assign id_ready = id_valid && !load_use && !flush && !mem_stall;

    assign count_stall = id_valid && load_use && !flush && !mem_stall;

    // The younger (EX) result wins over MEM when both write the same register.
    always_comb begin
        fwd_a = SEL_RF;
        if (rs1_ex && !ex_ld) begin
            fwd_a = SEL_EX;
        end else if (rs1_mem) begin
            fwd_a = SEL_MEM;
        end
    end

    always_comb begin
        fwd_b = SEL_RF;
        if (rs2_ex && !ex_ld) begin
            fwd_b = SEL_EX;
        end else if (rs2_mem) begin
            fwd_b = SEL_MEM;
        end
    end

    assign ex_valid = ex_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v      <= 1'b0;
            ex_ld     <= 1'b0;
            ex_rd     <= '0;
            mem_v     <= 1'b0;
            mem_ld    <= 1'b0;
            mem_rd    <= '0;
            stall_cnt <= 16'd0;
        end else begin
            if (!mem_stall) begin
                mem_v  <= ex_v;
                mem_rd <= ex_rd;
                mem_ld <= ex_ld;
                ex_v   <= id_ready;
                ex_rd  <= id_rd;
                ex_ld  <= id_is_load;
            end
            // Redirect kills the EX occupant even while memory is stalled; MEM
            // above already sampled the pre-flush EX contents.
            if (flush) begin
                ex_v <= 1'b0;
            end
            if (count_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/riscv_hazard_ctrl.md
RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REGN, default 32, the number of architectural registers.
REQ-002 The block SHALL have parameter REGA, default $clog2(REGN), the register-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port id_valid, input, 1 bit: a decoded instruction is offered for issue.
REQ-006 The block SHALL have ports id_rs1 and id_rs2, input, REGA bits each: source register addresses.
REQ-007 The block SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: the source is actually read.
REQ-008 The block SHALL have port id_rd, input, REGA bits: destination register address.
REQ-009 The block SHALL have port id_is_load, input, 1 bit: the offered instruction is a load (memfetch).
REQ-010 The block SHALL have port flush, input, 1 bit: branch redirect; squashes the EX slot and blocks issue.
REQ-011 The block SHALL have port mem_stall, input, 1 bit: memory busy; freezes both tracked slots.
REQ-012 The block SHALL have port id_ready, output, 1 bit: the offered instruction is issued this cycle.
REQ-013 The block SHALL have port ex_valid, output, 1 bit: registered; the EX slot holds a live instruction.
REQ-014 The block SHALL have ports fwd_a and fwd_b, output, 2 bits each: operand source selects (0 regfile, 1 EX result, 2 MEM result).
REQ-015 The block SHALL have ports ex_rd and mem_rd, output, REGA bits each: registered destinations of the EX and MEM slots.
REQ-016 The block SHALL have port stall_cnt, output, 16 bits: saturating count of load-use stall cycles.

Function
REQ-017 The block SHALL track two slots: EX (ex_v, ex_rd, ex_ld) for the instruction issued one cycle earlier and MEM (mem_v, mem_rd, mem_ld) for the one issued two cycles earlier.
REQ-018 A slot SHALL be treated as writing only if its valid bit is 1 and its rd is nonzero; register x0 never creates a hazard or a forward.
REQ-019 A source SHALL match a slot when its use flag is 1, its address is nonzero and it equals that writing slot's rd.
REQ-020 A load-use hazard SHALL exist when either used source matches the EX slot and ex_ld=1.
REQ-021 id_ready SHALL be combinational and equal id_valid AND NOT load-use AND NOT flush AND NOT mem_stall.
REQ-022 fwd_a (and fwd_b for rs2) SHALL select 1 on an EX-slot match with ex_ld=0, else 2 on a MEM-slot match, else 0; the EX match has priority over the MEM match.
REQ-023 fwd_a/fwd_b SHALL be meaningful only while id_ready=1 and SHALL read 0 when the source is unused.
REQ-024 On a cycle with mem_stall=0, MEM SHALL take EX's contents and EX SHALL load {id_rd, id_is_load} with valid=id_ready (a bubble if not issued).
REQ-025 On a cycle with mem_stall=1, both slots SHALL hold their contents and no issue SHALL occur.
REQ-026 flush=1 SHALL clear ex_v at the next edge regardless of mem_stall; the MEM slot SHALL follow REQ-024/025 using the pre-flush EX contents.
REQ-027 stall_cnt SHALL increment by 1 on each cycle where id_valid=1, load-use=1, flush=0 and mem_stall=0, and SHALL saturate at 16'hFFFF.
REQ-028 A load-use stall SHALL last exactly one cycle; on the next cycle the load is in MEM and the dependent instruction issues with select 2.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set ex_v, mem_v, ex_ld and mem_ld to 0, ex_rd and mem_rd to 0, and stall_cnt to 0.
REQ-030 With rst=1, ex_valid SHALL read 0 from the next edge; id_ready and fwd_* follow from the cleared state.
REQ-031 Reset SHALL override flush and mem_stall and SHALL discard any in-flight slot contents.

Verification
REQ-032 ALU rd=5, then a dependent instruction with rs1=5 and rs2=5 on the next cycle -> id_ready=1, fwd_a=1, fwd_b=1, stall_cnt unchanged.
REQ-033 Load rd=7, then a dependent instruction with rs2=7 -> cycle 1: id_ready=0 and stall_cnt=1; cycle 2: id_ready=1 and fwd_b=2.
REQ-034 EX and MEM slots both writing rd=3, consumer rs1=3 -> fwd_a=1 (priority); a consumer with rd=0 and rs1=0 -> fwd_a=0 and no stall.
REQ-035 Load rd=4 in EX with flush=1 and a dependent instruction offered -> id_ready=0, stall_cnt unchanged, ex_valid=0 next cycle.
REQ-036 mem_stall=1 for 3 cycles with a load rd=9 in EX -> ex_rd=9 and mem_rd held, id_ready=0; release -> mem_rd=9.
REQ-037 Force stall_cnt to 16'hFFFE and apply 3 load-use stalls -> stall_cnt=16'hFFFF; assert rst for one cycle mid-stall -> all outputs cleared next edge.
